map_table_ckpt_ctrl: RTL and testbench

MAP_TABLE_CKPT_CTRL -- requirements
Module: map_table_ckpt_ctrl

---
 rtl/map_table_ckpt_ctrl.sv | 160 ++++++++++++++++
 tb/tb_map_table_ckpt_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/map_table_ckpt_ctrl.sv
// Arbitrates rename / checkpoint save / checkpoint restore / ROB-walk revert
// traffic into the physical register map table and tracks live checkpoints.
module map_table_ckpt_ctrl #(
  parameter int MAP_TABLE_DEPTH = 4,
  parameter int ARCH_W          = 5,
  parameter int PHYS_W          = 7,
  parameter int ROB_W           = 5,
  parameter int COL_W           = $clog2(MAP_TABLE_DEPTH),
  parameter int CNT_W           = $clog2(MAP_TABLE_DEPTH)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              rename_req,
  input  logic [ARCH_W-1:0] rename_arch,
  input  logic [PHYS_W-1:0] rename_phys,
  input  logic              save_req,
  input  logic [ROB_W-1:0]  save_rob,
  input  logic              restore_req,
  input  logic              restore_failed,
  input  logic [ROB_W-1:0]  restore_rob,
  input  logic [COL_W-1:0]  restore_col,
  input  logic              revert_req,
  input  logic              revert_last,
  input  logic [ARCH_W-1:0] revert_arch,
  input  logic [PHYS_W-1:0] revert_safe,
  input  logic [PHYS_W-1:0] revert_spec,
  output logic              rename_ack,
  output logic              save_ack,
  output logic              restore_ack,
  output logic              revert_ack,
  output logic              mt_rename_valid,
  output logic              mt_save_valid,
  output logic              mt_restore_valid,
  output logic              mt_revert_valid,
  output logic [ARCH_W-1:0] mt_rename_arch,
  output logic [PHYS_W-1:0] mt_rename_phys,
  output logic [ROB_W-1:0]  mt_save_rob,
  output logic              mt_restore_failed,
  output logic [ROB_W-1:0]  mt_restore_rob,
  output logic [COL_W-1:0]  mt_restore_col,
  output logic [ARCH_W-1:0] mt_revert_arch,
  output logic [PHYS_W-1:0] mt_revert_safe,
  output logic [PHYS_W-1:0] mt_revert_spec,
  input  logic              mt_save_success,
  input  logic              mt_restore_success,
  output logic              restore_done,
  output logic              restore_ok,
  output logic              dispatch_stall,
  output logic              ckpt_full,
  output logic [CNT_W-1:0]  ckpt_count,
  output logic              err
);

  typedef enum logic [1:0] {NORMAL, REVERT, BUBBLE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAP_TABLE_DEPTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state_q <= NORMAL;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    err_d        = err_q;
    rename_ack   = 1'b0;
    save_ack     = 1'b0;
    restore_ack  = 1'b0;
    revert_ack   = 1'b0;
    restore_done = 1'b0;
    restore_ok   = 1'b0;
    if (!nRST) begin
      unique case (state_q)
        NORMAL: begin
          if (revert_req) begin
            revert_ack = 1'b1;
            if (revert_last) count_d = '0;
            else             state_d = REVERT;
          end else if (restore_req) begin
            restore_ack  = 1'b1;
            restore_done = 1'b1;
            // A restore with no live checkpoint is a protocol error; never wrap.
            if (count_q == '0) begin
              err_d = 1'b1;
            end else if (!restore_failed) begin
              count_d    = sat_dec(count_q);
              restore_ok = mt_restore_success;
            end else if (mt_restore_success) begin
              count_d    = '0;
              state_d    = BUBBLE;
              restore_ok = 1'b1;
            end
          end else if (save_req && (count_q != CNT_MAX)) begin
            save_ack = 1'b1;
            if (mt_save_success) count_d = sat_inc(count_q);
            else                 err_d   = 1'b1;
          end else if (rename_req) begin
            rename_ack = 1'b1;
          end
        end
        REVERT: begin
          if (revert_req) begin
            revert_ack = 1'b1;
            if (revert_last) begin
              count_d = '0;
              state_d = NORMAL;
            end
          end
        end
        BUBBLE:  state_d = NORMAL;
        default: state_d = NORMAL;
      endcase
    end
  end

  assign mt_rename_valid  = rename_ack;
  assign mt_save_valid    = save_ack;
  assign mt_restore_valid = restore_ack;
  assign mt_revert_valid  = revert_ack;

  assign mt_rename_arch    = rename_arch;
  assign mt_rename_phys    = rename_phys;
  assign mt_save_rob       = save_rob;
  assign mt_restore_failed = restore_failed;
  assign mt_restore_rob    = restore_rob;
  assign mt_restore_col    = restore_col;
  assign mt_revert_arch    = revert_arch;
  assign mt_revert_safe    = revert_safe;
  assign mt_revert_spec    = revert_spec;

  assign ckpt_full  = (count_q == CNT_MAX);
  assign ckpt_count = count_q;
  assign err        = err_q;

  // Dispatch must hold whenever its rename/save cannot be accepted this cycle.
  assign dispatch_stall = !nRST && ((state_q != NORMAL) || (save_req && ckpt_full) ||
                          (save_req && (revert_ack || restore_ack)) ||
                          (rename_req && (revert_ack || restore_ack || save_ack)));

endmodule

// File: tb/tb_map_table_ckpt_ctrl.sv
// Directed bench for map_table_ckpt_ctrl: expected output vectors are queued per
// step and popped for comparison when the DUT's outputs are sampled.
module tb_map_table_ckpt_ctrl;

  localparam int ARCH_W = 5;
  localparam int PHYS_W = 7;
  localparam int ROB_W  = 5;
  localparam int COL_W  = 2;
  localparam int CNT_W  = 2;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              rename_req, save_req, restore_req, restore_failed;
  logic              revert_req, revert_last;
  logic [ARCH_W-1:0] rename_arch, revert_arch;
  logic [PHYS_W-1:0] rename_phys, revert_safe, revert_spec;
  logic [ROB_W-1:0]  save_rob, restore_rob;
  logic [COL_W-1:0]  restore_col;
  logic              mt_save_success, mt_restore_success;

  logic              rename_ack, save_ack, restore_ack, revert_ack;
  logic              mt_rename_valid, mt_save_valid, mt_restore_valid, mt_revert_valid;
  logic [ARCH_W-1:0] mt_rename_arch, mt_revert_arch;
  logic [PHYS_W-1:0] mt_rename_phys, mt_revert_safe, mt_revert_spec;
  logic [ROB_W-1:0]  mt_save_rob, mt_restore_rob;
  logic              mt_restore_failed;
  logic [COL_W-1:0]  mt_restore_col;
  logic              restore_done, restore_ok, dispatch_stall, ckpt_full, err;
  logic [CNT_W-1:0]  ckpt_count;

  int tests = 0;
  int fails = 0;

  logic [14:0] sb_q[$];
  string       tag_q[$];

  map_table_ckpt_ctrl #(.MAP_TABLE_DEPTH(4), .ARCH_W(ARCH_W), .PHYS_W(PHYS_W), .ROB_W(ROB_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .rename_req(rename_req), .rename_arch(rename_arch), .rename_phys(rename_phys),
    .save_req(save_req), .save_rob(save_rob),
    .restore_req(restore_req), .restore_failed(restore_failed),
    .restore_rob(restore_rob), .restore_col(restore_col),
    .revert_req(revert_req), .revert_last(revert_last), .revert_arch(revert_arch),
    .revert_safe(revert_safe), .revert_spec(revert_spec),
    .rename_ack(rename_ack), .save_ack(save_ack), .restore_ack(restore_ack), .revert_ack(revert_ack),
    .mt_rename_valid(mt_rename_valid), .mt_save_valid(mt_save_valid),
    .mt_restore_valid(mt_restore_valid), .mt_revert_valid(mt_revert_valid),
    .mt_rename_arch(mt_rename_arch), .mt_rename_phys(mt_rename_phys),
    .mt_save_rob(mt_save_rob), .mt_restore_failed(mt_restore_failed),
    .mt_restore_rob(mt_restore_rob), .mt_restore_col(mt_restore_col),
    .mt_revert_arch(mt_revert_arch), .mt_revert_safe(mt_revert_safe), .mt_revert_spec(mt_revert_spec),
    .mt_save_success(mt_save_success), .mt_restore_success(mt_restore_success),
    .restore_done(restore_done), .restore_ok(restore_ok),
    .dispatch_stall(dispatch_stall), .ckpt_full(ckpt_full),
    .ckpt_count(ckpt_count), .err(err)
  );

  always #5 CLK = ~CLK;

  // ack bits ordered {rename, save, restore, revert}; valids must mirror acks
  function automatic logic [14:0] e(input logic [3:0] ack, input logic done, input logic ok,
                                    input logic stall, input logic full, input logic er,
                                    input logic [1:0] cnt);
    return {ack, ack, done, ok, stall, full, er, cnt};
  endfunction

  task automatic clr();
    rename_req = 0; save_req = 0; restore_req = 0; restore_failed = 0;
    revert_req = 0; revert_last = 0; mt_save_success = 0; mt_restore_success = 0;
    rename_arch = ARCH_W'($urandom); rename_phys = PHYS_W'($urandom);
    revert_arch = ARCH_W'($urandom); revert_safe = PHYS_W'($urandom);
    revert_spec = PHYS_W'($urandom); save_rob = ROB_W'($urandom);
    restore_rob = ROB_W'($urandom); restore_col = COL_W'($urandom);
  endtask

  task automatic check_step();
    logic [14:0] exp_v, got_v;
    string tg;
    exp_v = sb_q.pop_front();
    tg    = tag_q.pop_front();
    got_v = {rename_ack, save_ack, restore_ack, revert_ack,
             mt_rename_valid, mt_save_valid, mt_restore_valid, mt_revert_valid,
             restore_done, restore_ok, dispatch_stall, ckpt_full, err, ckpt_count};
    tests++;
    assert (got_v === exp_v) else begin
      fails++;
      $error("FAIL %s: got ack/vld/done/ok/stall/full/err/cnt=%b expected %b", tg, got_v, exp_v);
    end
    tests++;
    assert ({mt_rename_arch, mt_rename_phys, mt_save_rob, mt_restore_failed, mt_restore_rob,
             mt_restore_col, mt_revert_arch, mt_revert_safe, mt_revert_spec} ===
            {rename_arch, rename_phys, save_rob, restore_failed, restore_rob,
             restore_col, revert_arch, revert_safe, revert_spec}) else begin
      fails++;
      $error("FAIL %s_payload: got arch=%h phys=%h rob=%h expected arch=%h phys=%h rob=%h",
             tg, mt_rename_arch, mt_rename_phys, mt_save_rob, rename_arch, rename_phys, save_rob);
    end
  endtask

  task automatic cyc(input string tag, input logic [14:0] exp_v);
    sb_q.push_back(exp_v);
    tag_q.push_back(tag);
    @(negedge CLK);
    check_step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    clr();
    nRST = 1; rename_req = 1; revert_req = 1; save_req = 1;
    cyc("reset", e(4'b0000, 0, 0, 0, 0, 0, 2'd0));
    clr(); nRST = 0;

    rename_req = 1;                                cyc("rename", e(4'b1000, 0, 0, 0, 0, 0, 2'd0));
    clr(); save_req = 1; mt_save_success = 1; rename_req = 1;
                                                   cyc("save1_blk_ren", e(4'b0100, 0, 0, 1, 0, 0, 2'd0));
    clr(); save_req = 1; mt_save_success = 1;      cyc("save2", e(4'b0100, 0, 0, 0, 0, 0, 2'd1));
    clr(); save_req = 1; mt_save_success = 1;      cyc("save3", e(4'b0100, 0, 0, 0, 0, 0, 2'd2));
    clr(); save_req = 1; mt_save_success = 1;      cyc("save_full", e(4'b0000, 0, 0, 1, 1, 0, 2'd3));
    clr(); restore_req = 1; mt_restore_success = 1;
                                                   cyc("rest_ok_c3", e(4'b0010, 1, 1, 0, 1, 0, 2'd3));
    clr(); restore_req = 1; restore_failed = 1; mt_restore_success = 1; rename_req = 1;
                                                   cyc("rest_mispred", e(4'b0010, 1, 1, 1, 0, 0, 2'd2));
    clr(); rename_req = 1;                         cyc("bubble", e(4'b0000, 0, 0, 1, 0, 0, 2'd0));
    clr(); rename_req = 1;                         cyc("post_bubble", e(4'b1000, 0, 0, 0, 0, 0, 2'd0));
    clr(); save_req = 1; mt_save_success = 1;      cyc("resave1", e(4'b0100, 0, 0, 0, 0, 0, 2'd0));
    clr(); save_req = 1; mt_save_success = 1;      cyc("resave2", e(4'b0100, 0, 0, 0, 0, 0, 2'd1));
    clr(); restore_req = 1;                        cyc("rest_ok_fail", e(4'b0010, 1, 0, 0, 0, 0, 2'd2));
    clr(); restore_req = 1; restore_failed = 1;    cyc("rest_mp_nosucc", e(4'b0010, 1, 0, 0, 0, 0, 2'd1));
    clr(); restore_req = 1; mt_restore_success = 1;
                                                   cyc("rest_c1", e(4'b0010, 1, 1, 0, 0, 0, 2'd1));
    clr(); restore_req = 1; mt_restore_success = 1;
                                                   cyc("rest_empty", e(4'b0010, 1, 0, 0, 0, 0, 2'd0));
    clr();                                         cyc("err_sticky", e(4'b0000, 0, 0, 0, 0, 1, 2'd0));
    for (int i = 0; i < 3; i++) begin
      clr(); save_req = 1; mt_save_success = 1;
      cyc("fill", e(4'b0100, 0, 0, 0, 0, 1, 2'(i)));
    end
    clr(); revert_req = 1; restore_req = 1; save_req = 1; mt_save_success = 1;
    rename_req = 1; mt_restore_success = 1;        cyc("all_req", e(4'b0001, 0, 0, 1, 1, 1, 2'd3));
    clr(); rename_req = 1;                         cyc("revert_idle", e(4'b0000, 0, 0, 1, 1, 1, 2'd3));
    clr(); nRST = 1; revert_req = 1; rename_req = 1; restore_req = 1;
                                                   cyc("reset_in_revert", e(4'b0000, 0, 0, 0, 0, 0, 2'd0));
    clr(); nRST = 0; save_req = 1; rename_req = 1; cyc("save_fail", e(4'b0100, 0, 0, 1, 0, 0, 2'd0));
    clr(); revert_req = 1; restore_req = 1;        cyc("walk1", e(4'b0001, 0, 0, 0, 0, 1, 2'd0));
    clr(); revert_req = 1; restore_req = 1;        cyc("walk2", e(4'b0001, 0, 0, 1, 0, 1, 2'd0));
    clr(); revert_req = 1; revert_last = 1; restore_req = 1;
                                                   cyc("walk3_last", e(4'b0001, 0, 0, 1, 0, 1, 2'd0));
    clr(); restore_req = 1; mt_restore_success = 1;
                                                   cyc("rest_after_walk", e(4'b0010, 1, 0, 0, 0, 1, 2'd0));
    clr(); save_req = 1; mt_save_success = 1;      cyc("save_pre_rev", e(4'b0100, 0, 0, 0, 0, 1, 2'd0));
    clr(); revert_req = 1; revert_last = 1; rename_req = 1;
                                                   cyc("rev_single", e(4'b0001, 0, 0, 1, 0, 1, 2'd1));
    clr(); rename_req = 1;                         cyc("rename_final", e(4'b1000, 0, 0, 0, 0, 1, 2'd0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
